// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator: I/S/B/U/J extraction behind a registered output with a skid.
// Define ZICSR_IMM_EN to decode ImmSrc=101 as the CSR zero-extended rs1 immediate.
module imm_extend_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      In,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] Tag_In,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [XLEN-1:0]  Imm_Ext,
    output logic             Imm_Err,
    output logic [TAG_W-1:0] Tag_Out,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [2:0] {
        ImmI = 3'b000,
        ImmS = 3'b001,
        ImmB = 3'b010,
        ImmU = 3'b011,
        ImmJ = 3'b100,
        ImmZ = 3'b101
    } imm_src_e;

    logic [31:0]      imm32;
    logic             ext_bit;
    logic             dec_err;
    logic [XLEN-1:0]  dec_imm;
    logic             unused_opcode;

    logic             out_valid_q;
    logic [XLEN-1:0]  out_imm_q;
    logic             out_err_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             skid_valid_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic             skid_err_q;
    logic [TAG_W-1:0] skid_tag_q;

    logic             in_fire;
    logic             out_free;

    assign unused_opcode = ^In[6:0];

    // Build the 32-bit form first; ext_bit supplies the bits above 31 for XLEN=64.
    always_comb begin
        imm32   = '0;
        ext_bit = 1'b0;
        dec_err = 1'b0;
        case (imm_src_e'(ImmSrc))
            ImmI: begin
                imm32   = {{20{In[31]}}, In[31:20]};
                ext_bit = In[31];
            end
            ImmS: begin
                imm32   = {{20{In[31]}}, In[31:25], In[11:7]};
                ext_bit = In[31];
            end
            ImmB: begin
                imm32   = {{20{In[31]}}, In[7], In[30:25], In[11:8], 1'b0};
                ext_bit = In[31];
            end
            ImmU: begin
                imm32   = {In[31:12], 12'b0};
                ext_bit = In[31];
            end
            ImmJ: begin
                imm32   = {{12{In[31]}}, In[19:12], In[20], In[30:21], 1'b0};
                ext_bit = In[31];
            end
`ifdef ZICSR_IMM_EN
            ImmZ: begin
                imm32   = {27'b0, In[19:15]};
                ext_bit = 1'b0;
            end
`else
            ImmZ: dec_err = 1'b1;
`endif
            default: dec_err = 1'b1;
        endcase
    end

    if (XLEN > 32) begin : g_wide
        assign dec_imm = {{(XLEN-32){ext_bit}}, imm32};
    end else begin : g_narrow
        logic unused_ext;
        assign unused_ext = ext_bit;
        assign dec_imm    = imm32[XLEN-1:0];
    end

    assign in_ready = !skid_valid_q && !rst;
    assign in_fire  = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    // The skid only fills while the output is stalled, so it never takes a beat when out_free.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_err_q    <= 1'b0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_err_q   <= 1'b0;
            skid_tag_q   <= '0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_imm_q    <= skid_imm_q;
                out_err_q    <= skid_err_q;
                out_tag_q    <= skid_tag_q;
                skid_valid_q <= 1'b0;
            end else if (in_fire) begin
                out_valid_q <= 1'b1;
                out_imm_q   <= dec_imm;
                out_err_q   <= dec_err;
                out_tag_q   <= Tag_In;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_q <= 1'b1;
            skid_imm_q   <= dec_imm;
            skid_err_q   <= dec_err;
            skid_tag_q   <= Tag_In;
        end
    end

    assign out_valid = out_valid_q;
    assign Imm_Ext   = out_imm_q;
    assign Imm_Err   = out_err_q;
    assign Tag_Out   = out_tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: 32- and 64-bit instances on shared stimulus, checked against a
// queue-based model every cycle plus directed literal checks.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] In;
    logic [2:0]  ImmSrc;
    logic [7:0]  Tag_In;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready, Imm_Err, out_valid;
    logic [31:0] Imm_Ext;
    logic [7:0]  Tag_Out;
    logic        in_ready64, Imm_Err64, out_valid64;
    logic [63:0] Imm_Ext64;
    logic [7:0]  Tag_Out64;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .TAG_W(8)) dut (
        .clk(clk), .rst(rst), .In(In), .ImmSrc(ImmSrc), .Tag_In(Tag_In),
        .in_valid(in_valid), .in_ready(in_ready), .Imm_Ext(Imm_Ext), .Imm_Err(Imm_Err),
        .Tag_Out(Tag_Out), .out_valid(out_valid), .out_ready(out_ready)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst(rst), .In(In), .ImmSrc(ImmSrc), .Tag_In(Tag_In),
        .in_valid(in_valid), .in_ready(in_ready64), .Imm_Ext(Imm_Ext64), .Imm_Err(Imm_Err64),
        .Tag_Out(Tag_Out64), .out_valid(out_valid64), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Immediate value straight from the ISA field definitions, as a signed 64-bit number.
    function automatic logic [64:0] model(input logic [31:0] ins, input logic [2:0] src);
        longint v;
        logic   e;
        v = 0;
        e = 1'b0;
        case (src)
            3'd0: v = longint'($signed(ins[31:20]));
            3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = longint'($signed({ins[31:12], 12'h000}));
            3'd4: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
`ifdef ZICSR_IMM_EN
            3'd5: v = longint'(ins[19:15]);
`endif
            default: e = 1'b1;
        endcase
        return {e, v};
    endfunction

    typedef struct packed {
        logic [63:0] imm;
        logic        err;
        logic [7:0]  tag;
    } beat_t;

    beat_t q[$];
    logic  zero_hold = 1'b0;
    logic  started   = 1'b0;
    int    dep_tag[$];
    int    dep_cyc[$];

    // Model: at most two beats in flight, FIFO order, reset flushes everything.
    always @(posedge clk) begin
        logic        acc;
        logic [64:0] m;
        cycle++;
        if (out_valid && out_ready) begin
            dep_tag.push_back(int'(Tag_Out));
            dep_cyc.push_back(cycle);
        end
        if (rst) begin
            q.delete();
            zero_hold = 1'b1;
            started   = 1'b1;
        end else if (started) begin
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                m = model(In, ImmSrc);
                q.push_back({m[63:0], m[64], Tag_In});
                zero_hold = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(!rst && q.size() < 2));
            chk("in_ready64", 64'(in_ready64), 64'(!rst && q.size() < 2));
            if (q.size() > 0) begin
                chk("imm32", 64'(Imm_Ext), 64'(q[0].imm[31:0]));
                chk("imm64", Imm_Ext64, q[0].imm);
                chk("err", 64'(Imm_Err), 64'(q[0].err));
                chk("err64", 64'(Imm_Err64), 64'(q[0].err));
                chk("tag", 64'(Tag_Out), 64'(q[0].tag));
                chk("tag64", 64'(Tag_Out64), 64'(q[0].tag));
            end else if (zero_hold) begin
                chk("rst_imm", 64'(Imm_Ext), 64'd0);
                chk("rst_imm64", Imm_Ext64, 64'd0);
                chk("rst_err", 64'({Imm_Err, Imm_Err64}), 64'd0);
                chk("rst_tag", 64'({Tag_Out, Tag_Out64}), 64'd0);
            end
        end
    end

    // Holds the beat until accepted; returns just after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [7:0] tag);
        logic got;
        got      = 1'b0;
        In       = ins;
        ImmSrc   = src;
        Tag_In   = tag;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: tag %h never accepted", tag);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single beat on an empty pipe, then the output is checked against literals.
    task automatic lone(input string name, input logic [31:0] ins, input logic [2:0] src,
                        input logic [63:0] exp64, input logic exp_err);
        out_ready = 1'b1;
        idle(3);
        send(ins, src, 8'h5A);
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_imm32"}, 64'(Imm_Ext), 64'(exp64[31:0]));
        chk({name, "_imm64"}, Imm_Ext64, exp64);
        chk({name, "_err"}, 64'(Imm_Err), 64'(exp_err));
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vins[12] = '{32'hFE000EE3, 32'h12345037, 32'h80000037, 32'hFE112E23,
                              32'h8000006F, 32'h00500093, 32'h000FD073, 32'h0000006F,
                              32'h00C58063, 32'h7FFFF0EF, 32'hFFF00093, 32'h00000000};
    logic [2:0]  vsrc[12] = '{3'd2, 3'd3, 3'd3, 3'd1, 3'd4, 3'd0, 3'd5, 3'd7,
                              3'd2, 3'd4, 3'd6, 3'd0};

    initial begin
        logic [64:0] m;
        logic        z_err;
        logic [63:0] z_imm;
`ifdef ZICSR_IMM_EN
        z_err = 1'b0;
        z_imm = 64'h1F;
`else
        z_err = 1'b1;
        z_imm = 64'h0;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        In        = '0;
        ImmSrc    = '0;
        Tag_In    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        m = model(32'hFFF00093, 3'd0);
        chk("pin_I", m[63:0], 64'hFFFFFFFFFFFFFFFF);
        m = model(32'hFE000EE3, 3'd2);
        chk("pin_B", m[63:0], 64'hFFFFFFFFFFFFFFFC);
        m = model(32'h80000037, 3'd3);
        chk("pin_U", m[63:0], 64'hFFFFFFFF80000000);
        m = model(32'h000FD073, 3'd5);
        chk("pin_Z", m, {z_err, z_imm});

        lone("t1_I", 32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        lone("t2_B", 32'hFE000EE3, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        lone("t2_U", 32'h12345037, 3'd3, 64'h0000000012345000, 1'b0);
        lone("t3_U64", 32'h80000037, 3'd3, 64'hFFFFFFFF80000000, 1'b0);
        lone("t5_ill", 32'hFFFFFFFF, 3'd7, 64'h0, 1'b1);
        lone("t5_Z", 32'h000FD073, 3'd5, z_imm, z_err);

        // Mixed table with an irregular out_ready pattern.
        for (int i = 0; i < 12; i++) begin
            out_ready = (i % 3 != 1);
            send(vins[i], vsrc[i], 8'(8'h20 + i));
        end
        out_ready = 1'b1;
        idle(4);

        // Backpressure: 1 on output, 2 in skid, 3 held by the source.
        dep_tag.delete();
        dep_cyc.delete();
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, 8'd1);
        send(32'h00200093, 3'd0, 8'd2);
        fork
            send(32'h00300093, 3'd0, 8'd3);
            begin
                @(negedge clk);
                chk("t4_hold_tag", 64'(Tag_Out), 64'd1);
                chk("t4_in_ready", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        chk("t4_dep_count", 64'(dep_tag.size()), 64'd3);
        if (dep_tag.size() == 3) begin
            chk("t4_order", 64'({dep_tag[0][7:0], dep_tag[1][7:0], dep_tag[2][7:0]}),
                64'h010203);
            chk("t4_back2back", 64'({dep_cyc[1] - dep_cyc[0], dep_cyc[2] - dep_cyc[1]}),
                {32'd1, 32'd1});
        end

        // Reset with output and skid both full.
        out_ready = 1'b0;
        send(32'h06100093, 3'd0, 8'h61);
        send(32'h06200093, 3'd0, 8'h62);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_imm", 64'(Imm_Ext), 64'd0);
        chk("t6_tag", 64'(Tag_Out), 64'd0);
        dep_tag.delete();
        out_ready = 1'b1;
        idle(5);
        chk("t6_no_stale", 64'(dep_tag.size()), 64'd0);
        lone("t6_after", 32'h7FF00093, 3'd0, 64'h00000000000007FF, 1'b0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
